// File: rtl/spi_input_conditioner.sv
// SPI slave pin front end: synchronizes SCLK/CS/MOSI into the clk domain,
// filters glitches per channel and emits registered one-cycle edge pulses.
module spi_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_TIME   = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sclk_pin,
    input  logic i_cs_pin,
    input  logic i_mosi_pin,
    output logic o_sclk_cond,
    output logic o_cs_cond,
    output logic o_mosi_cond,
    output logic o_s_pos,
    output logic o_s_neg,
    output logic o_cs_fall,
    output logic o_cs_rise
);

    localparam int NCH     = 3;
    localparam int CH_SCLK = 0;
    localparam int CH_CS   = 1;
    localparam int CH_MOSI = 2;
    localparam int CNT_W   = $clog2(WAIT_TIME + 1);
    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_TIME);
    // Idle levels per channel: MOSI 0, CS 1 (inactive), SCLK 0
    localparam logic [NCH-1:0] IDLE_LVL = 3'b010;

    logic [SYNC_STAGES-1:0] r_sync [NCH];
    logic [CNT_W-1:0]       r_cnt  [NCH];
    logic [NCH-1:0]         r_cond;
    logic                   r_s_pos;
    logic                   r_s_neg;
    logic                   r_cs_fall;
    logic                   r_cs_rise;

    logic [NCH-1:0] w_pins;
    logic [NCH-1:0] w_sync_out;
    logic [NCH-1:0] w_accept;

    assign w_pins = {i_mosi_pin, i_cs_pin, i_sclk_pin};

    always_comb begin
        w_sync_out = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sync_out[c] = r_sync[c][SYNC_STAGES-1];
        end
    end

    // A channel accepts its new level on the (WAIT_TIME+1)-th consecutive mismatch
    always_comb begin
        w_accept = '0;
        for (int c = 0; c < NCH; c++) begin
            w_accept[c] = (r_sync[c][SYNC_STAGES-1] != r_cond[c]) && (r_cnt[c] == WAIT_CNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_sync[c] <= {SYNC_STAGES{IDLE_LVL[c]}};
                r_cnt[c]  <= '0;
            end
            r_cond <= IDLE_LVL;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_pins[c]};
                if (w_sync_out[c] == r_cond[c]) begin
                    r_cnt[c] <= '0;
                end else if (w_accept[c]) begin
                    r_cond[c] <= w_sync_out[c];
                    r_cnt[c]  <= '0;
                end else begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    // SCLK pulses use the CS level before this cycle's update, so an SCLK edge
    // accepted together with CS going active is not reported.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s_pos   <= 1'b0;
            r_s_neg   <= 1'b0;
            r_cs_fall <= 1'b0;
            r_cs_rise <= 1'b0;
        end else begin
            r_s_pos   <= w_accept[CH_SCLK] &  w_sync_out[CH_SCLK] & ~r_cond[CH_CS];
            r_s_neg   <= w_accept[CH_SCLK] & ~w_sync_out[CH_SCLK] & ~r_cond[CH_CS];
            r_cs_fall <= w_accept[CH_CS] & ~w_sync_out[CH_CS];
            r_cs_rise <= w_accept[CH_CS] &  w_sync_out[CH_CS];
        end
    end

    assign o_sclk_cond = r_cond[CH_SCLK];
    assign o_cs_cond   = r_cond[CH_CS];
    assign o_mosi_cond = r_cond[CH_MOSI];
    assign o_s_pos     = r_s_pos;
    assign o_s_neg     = r_s_neg;
    assign o_cs_fall   = r_cs_fall;
    assign o_cs_rise   = r_cs_rise;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Directed bench for spi_input_conditioner: a per-cycle vector table for reset,
// CS fall and MOSI glitch rejection, then hand sequences for SCLK/CS corner cases.
module tb_spi_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk_pin = 1'b0;
    logic cs_pin = 1'b1;
    logic mosi_pin = 1'b0;
    logic sclk_cond, cs_cond, mosi_cond;
    logic s_pos, s_neg, cs_fall, cs_rise;

    // {mosi_cond, cs_cond, sclk_cond, cs_rise, cs_fall, s_neg, s_pos}
    logic [6:0] outv;
    assign outv = {mosi_cond, cs_cond, sclk_cond, cs_rise, cs_fall, s_neg, s_pos};

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic       rst;
        logic [2:0] pins;  // {mosi, cs, sclk}
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    spi_input_conditioner dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_sclk_pin  (sclk_pin),
        .i_cs_pin    (cs_pin),
        .i_mosi_pin  (mosi_pin),
        .o_sclk_cond (sclk_cond),
        .o_cs_cond   (cs_cond),
        .o_mosi_cond (mosi_cond),
        .o_s_pos     (s_pos),
        .o_s_neg     (s_neg),
        .o_cs_fall   (cs_fall),
        .o_cs_rise   (cs_rise)
    );

    task automatic add_rows(input int n, input logic rst, input logic [2:0] pins,
                            input logic [2:0] cond, input logic [3:0] pulses);
        vec_t v;
        v.rst  = rst;
        v.pins = pins;
        v.exp  = {cond, pulses};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Drive inputs, let one active edge pass, then sample 1 time unit later
    task automatic step(input logic rst, input logic [2:0] pins);
        reset = rst;
        {mosi_pin, cs_pin, sclk_pin} = pins;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    initial begin
        int pos_cnt;
        int neg_cnt;
        logic lvl;
        logic [6:0] e;

        // Rows in cycle order; cond {mosi,cs,sclk}, pulses {cs_rise,cs_fall,s_neg,s_pos}
        add_rows(2, 1'b1, 3'b101, 3'b010, 4'b0000);  // reset with arbitrary pins
        add_rows(1, 1'b0, 3'b010, 3'b010, 4'b0000);  // first cycle after release
        add_rows(5, 1'b0, 3'b000, 3'b010, 4'b0000);  // cs pin low, filtering
        add_rows(1, 1'b0, 3'b000, 3'b000, 4'b0100);  // cs accepted, cs_fall
        add_rows(4, 1'b0, 3'b000, 3'b000, 4'b0000);
        add_rows(3, 1'b0, 3'b100, 3'b000, 4'b0000);  // 3-cycle mosi glitch
        add_rows(7, 1'b0, 3'b000, 3'b000, 4'b0000);  // rejected
        add_rows(4, 1'b0, 3'b100, 3'b000, 4'b0000);  // 4-cycle mosi pulse
        add_rows(1, 1'b0, 3'b000, 3'b000, 4'b0000);
        add_rows(4, 1'b0, 3'b000, 3'b100, 4'b0000);  // mosi accepted high
        add_rows(3, 1'b0, 3'b000, 3'b000, 4'b0000);  // and back low

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].pins);
            check($sformatf("tbl[%0d]", i), outv, tbl[i].exp);
        end

        // SCLK bursts with CS active: 8 periods of 16 clk
        pos_cnt = 0;
        neg_cnt = 0;
        for (int t = 0; t < 136; t++) begin
            lvl = (t < 128) && ((t % 16) < 8);
            step(1'b0, {1'b0, 1'b0, lvl});
            e = 7'b0;
            e[4] = (t >= 5) && ((t - 5) < 128) && (((t - 5) % 16) < 8);
            e[0] = (t >= 5) && (((t - 5) % 16) == 0) && ((t - 5) < 128);
            e[1] = (t >= 13) && (((t - 13) % 16) == 0) && ((t - 13) < 128);
            if (s_pos) pos_cnt++;
            if (s_neg) neg_cnt++;
            check($sformatf("sclk_active t=%0d", t), outv, e);
        end
        check("s_pos_count", 7'(pos_cnt), 7'd8);
        check("s_neg_count", 7'(neg_cnt), 7'd8);

        // CS release: cs_rise after 5 edges
        for (int t = 0; t < 8; t++) begin
            step(1'b0, 3'b010);
            e = {1'b0, (t >= 5), 1'b0, (t == 5), 3'b000};
            check($sformatf("cs_rise t=%0d", t), outv, e);
        end

        // SCLK toggling with CS inactive: level follows, no pulses
        for (int t = 0; t < 38; t++) begin
            lvl = (t < 32) && ((t % 16) < 8);
            step(1'b0, {1'b0, 1'b1, lvl});
            e = 7'b0;
            e[5] = 1'b1;
            e[4] = (t >= 5) && ((t - 5) < 32) && (((t - 5) % 16) < 8);
            check($sformatf("sclk_idle t=%0d", t), outv, e);
        end

        // SCLK rise accepted in the same cycle CS goes active: suppressed
        for (int t = 0; t < 21; t++) begin
            step(1'b0, {1'b0, 1'b0, (t < 10)});
            e = {1'b0, (t < 5), (t >= 5 && t < 15), 1'b0, (t == 5), (t == 15), 1'b0};
            check($sformatf("cs_sclk_same t=%0d", t), outv, e);
        end

        // Reset while the SCLK filter counter sits at 2
        for (int t = 0; t < 13; t++) begin
            step((t == 4), 3'b001);
            e = {1'b0, (t >= 4 && t < 10), (t >= 10), 1'b0, (t == 10), 2'b00};
            check($sformatf("mid_reset t=%0d", t), outv, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
